// File: rtl/fir_post_pkg.sv
// Shared constants and requantisation helpers for the FIR post-processing path.
// The helpers are pure functions so the bench reference model uses the very
// same arithmetic definition as the datapath.
package fir_post_pkg;

  localparam int IN_W  = 32;
  localparam int OUT_W = 16;
  localparam int SHIFT = 15;
  localparam int DEPTH = 16;
  localparam int CNT_W = 16;

  // Clamp limits of the signed OUT_W result.
  localparam int SAT_MAX = (32'sd1 <<< (OUT_W - 1)) - 32'sd1;
  localparam int SAT_MIN = -(32'sd1 <<< (OUT_W - 1));

  // Sign-extend to IN_W+1 bits and add half an LSB of the shifted result
  // (round-half-up); the extra bit keeps the addition from overflowing.
  function automatic logic signed [IN_W:0] round_add(input logic [IN_W-1:0] value,
                                                      input int          shift);
    logic signed [IN_W:0] half;
    half = (IN_W + 1)'(32'sd1);
    half = half <<< (shift - 1);
    return $signed({value[IN_W-1], value}) + half;
  endfunction

  // Arithmetic shift of a rounded value and clamp to OUT_W bits.
  // Returns {sat, result}.
  function automatic logic [OUT_W:0] shift_sat(input logic signed [IN_W:0] r1,
                                               input int                   shift);
    logic signed [IN_W:0] t;
    logic signed [IN_W:0] max_v;
    logic signed [IN_W:0] min_v;
    t     = r1 >>> shift;
    max_v = (IN_W + 1)'(SAT_MAX);
    min_v = (IN_W + 1)'(SAT_MIN);
    if (t > max_v) begin
      return {1'b1, 1'b0, {(OUT_W - 1){1'b1}}};
    end else if (t < min_v) begin
      return {1'b1, 1'b1, {(OUT_W - 1){1'b0}}};
    end else begin
      return {1'b0, t[OUT_W-1:0]};
    end
  endfunction

  // Full requantisation of one raw filter sample. Returns {sat, result}.
  function automatic logic [OUT_W:0] round_shift_sat(input logic [IN_W-1:0] value,
                                                     input int              shift);
    return shift_sat(round_add(value, shift), shift);
  endfunction

endpackage

// File: rtl/fir_post_fifo.sv
// Synchronous FIFO with first-word-fall-through registered output.
// The head entry stays in storage until popped, so level counts it; the
// output register is refreshed from storage one cycle after a write into an
// empty FIFO, and a pop is only honoured while valid_o is high.
module fir_post_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [W-1:0]             data_i,
  input  logic                     pop_i,
  output logic [W-1:0]             data_o,
  output logic                     valid_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [LVL_W-1:0] left_s;
  logic             valid_q, valid_d;
  logic [W-1:0]     data_q, data_d;
  logic             full_s, pop_ok_s, push_ok_s;

  // Next-state for pointers, occupancy and the head output register.
  always_comb begin
    full_s    = (level_q == LVL_W'(DEPTH));
    pop_ok_s  = pop_i & valid_q;
    push_ok_s = push_i & (~full_s | pop_ok_s);

    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_ok_s, pop_ok_s})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    // Entries left after this cycle's pop, not counting this cycle's write,
    // so a fresh write into an empty FIFO shows up one cycle later.
    left_s  = level_q - {{(LVL_W - 1){1'b0}}, pop_ok_s};
    valid_d = valid_q;
    data_d  = data_q;
    if (!valid_q || pop_ok_s) begin
      valid_d = (left_s != '0);
      if (left_s != '0) begin
        data_d = mem_q[rd_ptr_d];
      end else begin
        data_d = data_q;
      end
    end else begin
      valid_d = valid_q;
      data_d  = data_q;
    end
  end

  // Sample storage; contents need no reset because level gates every read.
  always_ff @(posedge clk_i) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign full_o  = full_s;
  assign level_o = level_q;

endmodule

// File: rtl/fir_requant_fifo.sv
// Requantises the FIR's full-precision stream (round, shift, saturate) in a
// two-stage pipeline and buffers it toward an AXI-Stream master. The input
// cannot be stalled, so samples arriving at a full FIFO with no pop are
// dropped and flagged. Widths follow the fir_post_pkg helpers.
module fir_requant_fifo #(
  parameter int IN_W  = fir_post_pkg::IN_W,
  parameter int OUT_W = fir_post_pkg::OUT_W,
  parameter int SHIFT = fir_post_pkg::SHIFT,
  parameter int DEPTH = fir_post_pkg::DEPTH,
  parameter int CNT_W = fir_post_pkg::CNT_W
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic [IN_W-1:0]        s_axis_tdata,
  input  logic                   s_axis_tvalid,
  output logic [OUT_W-1:0]       m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   overflow,
  output logic [CNT_W-1:0]       sat_count,
  input  logic                   clr_status
);

  import fir_post_pkg::*;

  logic                 s1_valid_q;
  logic signed [IN_W:0] s1_data_q;
  logic                 s2_valid_q;
  logic                 s2_sat_q;
  logic [OUT_W-1:0]     s2_data_q;

  logic                 full_s, pop_s, push_s, drop_s, sat_ev_s;
  logic                 overflow_q, overflow_d;
  logic [CNT_W-1:0]     sat_count_q, sat_count_d;

  // Stage 1 adds the rounding offset; stage 2 shifts and clamps.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_sat_q   <= 1'b0;
      s2_data_q  <= '0;
    end else begin
      s1_valid_q <= s_axis_tvalid;
      if (s_axis_tvalid) begin
        s1_data_q <= round_add(s_axis_tdata, SHIFT);
      end
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        {s2_sat_q, s2_data_q} <= shift_sat(s1_data_q, SHIFT);
      end
    end
  end

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign pop_s    = m_axis_tvalid & m_axis_tready;
  assign push_s   = s2_valid_q & (~full_s | pop_s);
  assign drop_s   = s2_valid_q & full_s & ~pop_s;
  assign sat_ev_s = s2_valid_q & s2_sat_q;

  fir_post_fifo #(
    .W     (OUT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (aclk),
    .rst_i   (areset),
    .push_i  (push_s),
    .data_i  (s2_data_q),
    .pop_i   (pop_s),
    .data_o  (m_axis_tdata),
    .valid_o (m_axis_tvalid),
    .full_o  (full_s),
    .level_o (fifo_level)
  );

  // Sticky status next-state; a clear still records this cycle's events.
  always_comb begin
    overflow_d  = overflow_q;
    sat_count_d = sat_count_q;
    if (clr_status) begin
      overflow_d = drop_s;
      if (sat_ev_s) begin
        sat_count_d = CNT_W'(1);
      end else begin
        sat_count_d = '0;
      end
    end else begin
      overflow_d = overflow_q | drop_s;
      if (sat_ev_s && (sat_count_q != '1)) begin
        sat_count_d = sat_count_q + CNT_W'(1);
      end else begin
        sat_count_d = sat_count_q;
      end
    end
  end

  // Status registers.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      overflow_q  <= 1'b0;
      sat_count_q <= '0;
    end else begin
      overflow_q  <= overflow_d;
      sat_count_q <= sat_count_d;
    end
  end

  assign overflow  = overflow_q;
  assign sat_count = sat_count_q;

endmodule

// File: tb/tb_fir_requant_fifo.sv
// Directed and random checks of the requantising FIFO.
module tb_fir_requant_fifo;

  import fir_post_pkg::*;

  logic        aclk;
  logic        areset;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic [15:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [4:0]  fifo_level;
  logic        overflow;
  logic [15:0] sat_count;
  logic        clr_status;

  int n_checks;
  int n_pass;

  // reference model state for the random run
  logic [15:0] mq[$];
  logic        m_s1v, m_s2v;
  logic [16:0] m_s1r, m_s2r;
  logic        m_drop;
  logic [15:0] m_sat;

  fir_requant_fifo dut (
    .aclk          (aclk),
    .areset        (areset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .fifo_level    (fifo_level),
    .overflow      (overflow),
    .sat_count     (sat_count),
    .clr_status    (clr_status)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    areset        = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = 32'h0;
    m_axis_tready = 1'b0;
    clr_status    = 1'b0;
    tick();
    tick();
    areset = 1'b0;
    tick();
  endtask

  task automatic push_seq(input logic [31:0] d);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    tick();
    s_axis_tvalid = 1'b0;
  endtask

  task automatic stress_cycle(input logic v, input logic [31:0] d, input logic r);
    logic        mv;
    logic [15:0] md;
    logic        pop;
    s_axis_tvalid = v;
    s_axis_tdata  = d;
    m_axis_tready = r;
    mv = m_axis_tvalid;
    md = m_axis_tdata;
    tick();
    pop = mv & r;
    if (pop) begin
      if (mq.size() == 0) begin
        check("stress_spurious_valid", {31'h0, mv}, 32'h0);
      end else begin
        check("stress_data", {16'h0, md}, {16'h0, mq.pop_front()});
      end
    end
    if (m_s2v) begin
      if (mq.size() == 16 && !pop) begin
        m_drop = 1'b1;
      end else begin
        mq.push_back(m_s2r[15:0]);
      end
      if (m_s2r[16] && m_sat != 16'hFFFF) m_sat++;
    end
    m_s2v = m_s1v;
    m_s2r = m_s1r;
    m_s1v = v;
    m_s1r = round_shift_sat(d, fir_post_pkg::SHIFT);
    check("stress_level", {27'h0, fifo_level}, mq.size());
  endtask

  logic [31:0] rin  [6];
  logic [15:0] rexp [6];

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rin  = '{32'd16384, 32'd16383, 32'hFFFF_C000, 32'hFFFF_BFFF, 32'h7FFF_FFFF, 32'h8000_0000};
    rexp = '{16'h0001, 16'h0000, 16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000};

    // reset state
    do_reset();
    check("rst_tvalid", {31'h0, m_axis_tvalid}, 32'h0);
    check("rst_tdata", {16'h0, m_axis_tdata}, 32'h0);
    check("rst_level", {27'h0, fifo_level}, 32'h0);
    check("rst_overflow", {31'h0, overflow}, 32'h0);
    check("rst_sat", {16'h0, sat_count}, 32'h0);

    // rounding, saturation and 3-cycle latency
    m_axis_tready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      s_axis_tvalid = (c < 6);
      s_axis_tdata  = (c < 6) ? rin[c] : 32'h0;
      tick();
      if (c + 1 == 3) check("rnd_latency", {31'h0, m_axis_tvalid}, 32'h0);
      if (c + 1 >= 4 && c + 1 <= 9) begin
        check("rnd_valid", {31'h0, m_axis_tvalid}, 32'h1);
        check("rnd_data", {16'h0, m_axis_tdata}, {16'h0, rexp[c - 3]});
      end
      if (c + 1 == 10) check("rnd_valid_end", {31'h0, m_axis_tvalid}, 32'h0);
    end
    check("rnd_sat_count", {16'h0, sat_count}, 32'h2);
    check("rnd_level", {27'h0, fifo_level}, 32'h0);

    // backpressure: 17 samples into 16 entries
    do_reset();
    for (int i = 1; i <= 17; i++) push_seq(32'(i) << 15);
    for (int i = 0; i < 4; i++) tick();
    check("bp_level", {27'h0, fifo_level}, 32'd16);
    check("bp_overflow", {31'h0, overflow}, 32'h1);
    check("bp_head", {16'h0, m_axis_tdata}, 32'h1);
    m_axis_tready = 1'b1;
    for (int i = 2; i <= 16; i++) begin
      tick();
      check("bp_valid", {31'h0, m_axis_tvalid}, 32'h1);
      check("bp_data", {16'h0, m_axis_tdata}, 32'(i));
    end
    tick();
    check("bp_empty_valid", {31'h0, m_axis_tvalid}, 32'h0);
    check("bp_empty_level", {27'h0, fifo_level}, 32'h0);
    for (int i = 0; i < 3; i++) tick();
    check("bp_no_17th", {31'h0, m_axis_tvalid}, 32'h0);

    // full FIFO with write and pop in the same cycle
    do_reset();
    for (int i = 1; i <= 16; i++) push_seq(32'(i) << 15);
    for (int i = 0; i < 4; i++) tick();
    check("fr_level_full", {27'h0, fifo_level}, 32'd16);
    for (int j = 0; j < 12; j++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 32'(17 + j) << 15;
      m_axis_tready = (j >= 2);
      tick();
      if (j >= 2) begin
        check("fr_level", {27'h0, fifo_level}, 32'd16);
        check("fr_head", {16'h0, m_axis_tdata}, 32'(j));
      end
    end
    s_axis_tvalid = 1'b0;
    check("fr_overflow", {31'h0, overflow}, 32'h0);

    // status clear priority
    do_reset();
    push_seq(32'h7FFF_FFFF);
    push_seq(32'h7FFF_FFFF);
    for (int i = 3; i <= 17; i++) push_seq(32'h0);
    for (int i = 0; i < 4; i++) tick();
    check("clr_pre_sat", {16'h0, sat_count}, 32'h2);
    check("clr_pre_ovf", {31'h0, overflow}, 32'h1);
    push_seq(32'h7FFF_FFFF);
    tick();
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    check("clr_same_sat", {16'h0, sat_count}, 32'h1);
    check("clr_same_ovf", {31'h0, overflow}, 32'h1);
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    check("clr_alone_sat", {16'h0, sat_count}, 32'h0);
    check("clr_alone_ovf", {31'h0, overflow}, 32'h0);

    // asynchronous reset mid-stream
    do_reset();
    for (int i = 1; i <= 5; i++) push_seq(32'(i) << 15);
    for (int i = 0; i < 3; i++) tick();
    check("mid_level_before", {27'h0, fifo_level}, 32'd5);
    #2;
    areset = 1'b1;
    #1;
    check("mid_rst_valid", {31'h0, m_axis_tvalid}, 32'h0);
    check("mid_rst_level", {27'h0, fifo_level}, 32'h0);
    tick();
    areset        = 1'b0;
    m_axis_tready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      s_axis_tvalid = (c == 0);
      s_axis_tdata  = 32'(3) << 15;
      tick();
      if (c + 1 == 3) check("mid_new_latency", {31'h0, m_axis_tvalid}, 32'h0);
      if (c + 1 == 4) begin
        check("mid_new_valid", {31'h0, m_axis_tvalid}, 32'h1);
        check("mid_new_data", {16'h0, m_axis_tdata}, 32'h3);
      end
    end

    // random stress against the package reference model
    do_reset();
    mq.delete();
    m_s1v  = 1'b0;
    m_s2v  = 1'b0;
    m_s1r  = 17'h0;
    m_s2r  = 17'h0;
    m_drop = 1'b0;
    m_sat  = 16'h0;
    for (int i = 0; i < 10000; i++) begin
      logic        v, r;
      logic [31:0] d;
      v = ($urandom_range(0, 9) < 8);
      if (((i / 500) % 2) == 1) r = ($urandom_range(0, 9) < 9);
      else                      r = ($urandom_range(0, 9) < 3);
      if ($urandom_range(0, 3) == 0) d = $urandom();
      else d = 32'($urandom_range(0, 32'h00FF_FFFF)) - 32'h0080_0000;
      stress_cycle(v, d, r);
    end
    for (int i = 0; i < 40; i++) stress_cycle(1'b0, 32'h0, 1'b1);
    check("stress_drain_valid", {31'h0, m_axis_tvalid}, 32'h0);
    check("stress_drain_level", {27'h0, fifo_level}, 32'h0);
    check("stress_overflow", {31'h0, overflow}, {31'h0, m_drop});
    check("stress_sat_count", {16'h0, sat_count}, {16'h0, m_sat});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
